// File: rtl/i2c_seq_if.sv
// ============================================================================
// Module   : i2c_seq_if
// Purpose  : Command/status bundle between the I2C sequencer and the byte-master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface i2c_seq_if;
    logic       i2c_start;
    logic       i2c_read;
    logic [6:0] i2c_addr;
    logic       i2c_wlen;
    logic [7:0] i2c_wdata1;
    logic [7:0] i2c_wdata2;
    logic [7:0] i2c_rdata;
    logic       i2c_end;    // 1 = master idle
    logic       i2c_ack;    // 1 = NACK seen during the transaction

    modport master (
        output i2c_start, i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2,
        input  i2c_rdata, i2c_end, i2c_ack
    );

    modport slave (
        input  i2c_start, i2c_read, i2c_addr, i2c_wlen, i2c_wdata1, i2c_wdata2,
        output i2c_rdata, i2c_end, i2c_ack
    );
endinterface

`default_nettype wire

// File: rtl/i2c_seq.sv
// ============================================================================
// Module   : i2c_seq
// Purpose  : Register-table walker with NACK retry, arbitrated with one host
//            requester in front of an I2C byte-master.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module i2c_seq #(
    parameter int TBL_AW     = 6,
    parameter int RETRIES    = 3,
    parameter int GAP_CYCLES = 1000
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              init_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   error_o,
    output logic [TBL_AW-1:0]      err_idx_o,
    output logic [TBL_AW-1:0]      tbl_addr_o,
    input  wire logic [24:0]       tbl_data_i,
    input  wire logic              hreq_i,
    input  wire logic              hread_i,
    input  wire logic [6:0]        haddr_i,
    input  wire logic              hwlen_i,
    input  wire logic [7:0]        hwdata1_i,
    input  wire logic [7:0]        hwdata2_i,
    output logic                   hdone_o,
    output logic                   hnack_o,
    output logic [7:0]             hrdata_o,
    i2c_seq_if.master              bus
);

    localparam int RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;
    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [RW-1:0]     C_RETRY_MAX = RW'(RETRIES);
    localparam logic [GW-1:0]     C_GAP_LAST  = GW'(GAP_CYCLES - 1);
    localparam logic [TBL_AW-1:0] C_IDX_LAST  = {TBL_AW{1'b1}};

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        FETCH    = 4'd1,
        LATCH    = 4'd2,
        ISSUE    = 4'd3,
        ACCEPT   = 4'd4,
        WAIT_END = 4'd5,
        EVAL     = 4'd6,
        GAP      = 4'd7,
        HOST     = 4'd8
    } state_t;

    localparam state_t C_AFTER_EVAL = (GAP_CYCLES == 0) ? FETCH : GAP;

    state_t            state_q, state_d;
    logic              init_q, hreq_q;
    logic              pend_q, pend_d;
    logic              restart_q, restart_d;
    logic              host_q, host_d;
    logic [TBL_AW-1:0] idx_q, idx_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [GW-1:0]     gap_q, gap_d;
    logic              ack_q, ack_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [TBL_AW-1:0] err_idx_q, err_idx_d;
    logic              hdone_q, hdone_d;
    logic              hnack_q, hnack_d;
    logic [7:0]        hrdata_q, hrdata_d;
    logic              start_q, start_d;
    logic              read_q, read_d;
    logic [6:0]        addr_q, addr_d;
    logic              wlen_q, wlen_d;
    logic [7:0]        wd1_q, wd1_d;
    logic [7:0]        wd2_q, wd2_d;

    logic w_init_edge, w_hreq_edge, w_restart, w_advance;

    assign w_init_edge = init_i & ~init_q;
    assign w_hreq_edge = hreq_i & ~hreq_q;
    assign w_restart   = w_init_edge | restart_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            init_q    <= 1'b0;
            hreq_q    <= 1'b0;
            pend_q    <= 1'b0;
            restart_q <= 1'b0;
            host_q    <= 1'b0;
            idx_q     <= '0;
            retry_q   <= '0;
            gap_q     <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            err_idx_q <= '0;
            hdone_q   <= 1'b0;
            hnack_q   <= 1'b0;
            hrdata_q  <= '0;
            start_q   <= 1'b0;
            read_q    <= 1'b0;
            addr_q    <= '0;
            wlen_q    <= 1'b0;
            wd1_q     <= '0;
            wd2_q     <= '0;
        end else begin
            state_q   <= state_d;
            init_q    <= init_i;
            hreq_q    <= hreq_i;
            pend_q    <= pend_d;
            restart_q <= restart_d;
            host_q    <= host_d;
            idx_q     <= idx_d;
            retry_q   <= retry_d;
            gap_q     <= gap_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
            err_idx_q <= err_idx_d;
            hdone_q   <= hdone_d;
            hnack_q   <= hnack_d;
            hrdata_q  <= hrdata_d;
            start_q   <= start_d;
            read_q    <= read_d;
            addr_q    <= addr_d;
            wlen_q    <= wlen_d;
            wd1_q     <= wd1_d;
            wd2_q     <= wd2_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        restart_d = restart_q;
        host_d    = host_q;
        idx_d     = idx_q;
        retry_d   = retry_q;
        gap_d     = gap_q;
        ack_d     = ack_q;
        busy_d    = busy_q;
        done_d    = done_q;
        error_d   = error_q;
        err_idx_d = err_idx_q;
        hdone_d   = 1'b0;
        hnack_d   = hnack_q;
        hrdata_d  = hrdata_q;
        start_d   = start_q;
        read_d    = read_q;
        addr_d    = addr_q;
        wlen_d    = wlen_q;
        wd1_d     = wd1_q;
        wd2_d     = wd2_q;
        w_advance = 1'b0;

        // Requests that arrive while the master is owned are parked until IDLE.
        if (state_q != IDLE) begin
            if (w_hreq_edge) pend_d = 1'b1;
            if (w_init_edge) restart_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (w_restart) begin
                    idx_d     = '0;
                    retry_d   = '0;
                    error_d   = 1'b0;
                    done_d    = 1'b0;
                    busy_d    = 1'b1;
                    host_d    = 1'b0;
                    restart_d = 1'b0;
                    if (w_hreq_edge) pend_d = 1'b1;
                    state_d   = FETCH;
                end else if (w_hreq_edge || pend_q) begin
                    pend_d  = 1'b0;
                    host_d  = 1'b1;
                    read_d  = hread_i;
                    addr_d  = haddr_i;
                    wlen_d  = hwlen_i;
                    wd1_d   = hwdata1_i;
                    wd2_d   = hwdata2_i;
                    state_d = HOST;
                end
            end
            HOST:  state_d = ISSUE;
            FETCH: state_d = LATCH;
            LATCH: begin
                if (tbl_data_i[24]) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    read_d  = 1'b0;
                    wlen_d  = tbl_data_i[23];
                    addr_d  = tbl_data_i[22:16];
                    wd1_d   = tbl_data_i[15:8];
                    wd2_d   = tbl_data_i[7:0];
                    state_d = ISSUE;
                end
            end
            // The master is never reset, so always wait for it to be idle first.
            ISSUE: begin
                if (bus.i2c_end) begin
                    start_d = 1'b1;
                    state_d = ACCEPT;
                end
            end
            ACCEPT: begin
                if (!bus.i2c_end) begin
                    start_d = 1'b0;
                    state_d = WAIT_END;
                end
            end
            WAIT_END: begin
                if (bus.i2c_end) begin
                    ack_d   = bus.i2c_ack;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                if (host_q) begin
                    hdone_d = 1'b1;
                    hnack_d = ack_q;
                    if (read_q) hrdata_d = bus.i2c_rdata;
                    host_d  = 1'b0;
                    state_d = IDLE;
                end else if (!w_restart) begin
                    if (!ack_q) begin
                        w_advance = 1'b1;
                    end else if (retry_q < C_RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        gap_d   = '0;
                        state_d = C_AFTER_EVAL;
                    end else begin
                        error_d   = 1'b1;
                        err_idx_d = idx_q;
                        w_advance = 1'b1;
                    end
                    if (w_advance) begin
                        retry_d = '0;
                        if (idx_q == C_IDX_LAST) begin
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            gap_d   = '0;
                            state_d = C_AFTER_EVAL;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == C_GAP_LAST) state_d = FETCH;
                else                     gap_d   = gap_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // A new INIT outside a live transfer discards the walk and starts over.
        if ((state_q == FETCH || state_q == LATCH || state_q == GAP ||
             (state_q == EVAL && !host_q)) && w_restart) begin
            idx_d     = '0;
            retry_d   = '0;
            error_d   = 1'b0;
            done_d    = 1'b0;
            busy_d    = 1'b1;
            restart_d = 1'b0;
            state_d   = FETCH;
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign error_o        = error_q;
    assign err_idx_o      = err_idx_q;
    assign tbl_addr_o     = idx_q;
    assign hdone_o        = hdone_q;
    assign hnack_o        = hnack_q;
    assign hrdata_o       = hrdata_q;
    assign bus.i2c_start  = start_q;
    assign bus.i2c_read   = read_q;
    assign bus.i2c_addr   = addr_q;
    assign bus.i2c_wlen   = wlen_q;
    assign bus.i2c_wdata1 = wd1_q;
    assign bus.i2c_wdata2 = wd2_q;

endmodule

`default_nettype wire
